// File: rtl/cam_pattern_src.sv
// Camera sensor emulator: drives an 8-bit FV/LV/D pixel bus carrying RGB565
// test patterns, high byte first, for bring-up without a real sensor attached.
module cam_pattern_src #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int FV_LEAD  = 4,
  parameter int V_BLANK  = 1000
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic        EN_I,
  input  logic [1:0]  MODE_I,
  output logic [7:0]  D_O,
  output logic        LV_O,
  output logic        FV_O,
  output logic [15:0] FRAME_CNT_O,
  output logic        BUSY_O
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FV_LEAD,
    S_LINE_ACT,
    S_LINE_BLANK,
    S_FRAME_BLANK
  } state_t;

  localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
  localparam logic [15:0] HBL_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VBL_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] X_END     = 16'(H_ACTIVE);
  localparam logic [15:0] Y_END     = 16'(V_ACTIVE);
  localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 8 - 1);

  state_t      state;
  logic [15:0] tmr;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic        phase;
  logic [15:0] pix_r;
  logic [1:0]  mode_r;

  logic [15:0] pix;
  logic [15:0] nxt_bar_cnt;
  logic [2:0]  nxt_bar_idx;

  // x, bar_idx and bar_cnt describe the next pixel to start, so the pixel word
  // is ready on the edge that enters LINE_ACT and D_O has no latency vs LV_O.
  // y is bumped at line end for the same reason, so it briefly equals V_ACTIVE.
  always_comb begin
    pix = '0;
    case (mode_r)
      2'b00: begin
        case (bar_idx)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'b01:   pix = x;
      2'b10:   pix = {FRAME_CNT_O[7:0], FRAME_CNT_O[7:0]};
      default: pix = x + y;
    endcase
  end

  always_comb begin
    nxt_bar_cnt = bar_cnt + 16'd1;
    nxt_bar_idx = bar_idx;
    if (bar_cnt == BAR_LAST) begin
      nxt_bar_cnt = '0;
      nxt_bar_idx = bar_idx + 3'd1;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state       <= S_IDLE;
      tmr         <= '0;
      x           <= '0;
      y           <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      phase       <= 1'b0;
      pix_r       <= '0;
      mode_r      <= '0;
      D_O         <= '0;
      LV_O        <= 1'b0;
      FV_O        <= 1'b0;
      FRAME_CNT_O <= '0;
      BUSY_O      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (EN_I) begin
            state  <= S_FV_LEAD;
            FV_O   <= 1'b1;
            BUSY_O <= 1'b1;
            mode_r <= MODE_I;
            tmr    <= '0;
            y      <= '0;
          end
        end

        S_FV_LEAD: begin
          if (tmr == LEAD_LAST) begin
            state   <= S_LINE_ACT;
            LV_O    <= 1'b1;
            D_O     <= pix[15:8];
            pix_r   <= pix;
            phase   <= 1'b0;
            x       <= x + 16'd1;
            bar_cnt <= nxt_bar_cnt;
            bar_idx <= nxt_bar_idx;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end

        S_LINE_ACT: begin
          if (!phase) begin
            D_O   <= pix_r[7:0];
            phase <= 1'b1;
          end else if (x == X_END) begin
            state   <= S_LINE_BLANK;
            LV_O    <= 1'b0;
            D_O     <= '0;
            x       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            y       <= y + 16'd1;
            tmr     <= '0;
          end else begin
            D_O     <= pix[15:8];
            pix_r   <= pix;
            phase   <= 1'b0;
            x       <= x + 16'd1;
            bar_cnt <= nxt_bar_cnt;
            bar_idx <= nxt_bar_idx;
          end
        end

        S_LINE_BLANK: begin
          if (tmr != HBL_LAST) begin
            tmr <= tmr + 16'd1;
          end else if (y == Y_END) begin
            state       <= S_FRAME_BLANK;
            FV_O        <= 1'b0;
            FRAME_CNT_O <= FRAME_CNT_O + 16'd1;
            tmr         <= '0;
          end else begin
            state   <= S_LINE_ACT;
            LV_O    <= 1'b1;
            D_O     <= pix[15:8];
            pix_r   <= pix;
            phase   <= 1'b0;
            x       <= x + 16'd1;
            bar_cnt <= nxt_bar_cnt;
            bar_idx <= nxt_bar_idx;
          end
        end

        S_FRAME_BLANK: begin
          if (tmr != VBL_LAST) begin
            tmr <= tmr + 16'd1;
          end else if (EN_I) begin
            state  <= S_FV_LEAD;
            FV_O   <= 1'b1;
            mode_r <= MODE_I;
            tmr    <= '0;
            y      <= '0;
          end else begin
            state  <= S_IDLE;
            BUSY_O <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          FV_O   <= 1'b0;
          LV_O   <= 1'b0;
          D_O    <= '0;
          BUSY_O <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pattern_src.sv
// Scoreboard bench for cam_pattern_src: expected bytes are queued per frame and
// a negedge monitor checks every byte; frame timing is checked by watch_frame.
module tb_cam_pattern_src;

  localparam int H  = 8;
  localparam int V  = 2;
  localparam int HB = 3;
  localparam int FL = 2;
  localparam int VB = 5;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        CLK_I;
  logic        RSTN_I;
  logic        EN_I;
  logic [1:0]  MODE_I;
  logic [7:0]  D_O;
  logic        LV_O;
  logic        FV_O;
  logic [15:0] FRAME_CNT_O;
  logic        BUSY_O;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic [7:0] exp_q [$];

  cam_pattern_src #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .H_BLANK  (HB),
    .FV_LEAD  (FL),
    .V_BLANK  (VB)
  ) dut (
    .CLK_I       (CLK_I),
    .RSTN_I      (RSTN_I),
    .EN_I        (EN_I),
    .MODE_I      (MODE_I),
    .D_O         (D_O),
    .LV_O        (LV_O),
    .FV_O        (FV_O),
    .FRAME_CNT_O (FRAME_CNT_O),
    .BUSY_O      (BUSY_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] mode, input logic [15:0] fc);
    logic [15:0] p;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        case (mode)
          2'b00:   p = BARS[xx];
          2'b01:   p = 16'(xx);
          2'b10:   p = {fc[7:0], fc[7:0]};
          default: p = 16'(xx + yy);
        endcase
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  always @(negedge CLK_I) begin
    if (RSTN_I) begin
      if (LV_O) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL pix_byte: got %0h, expected no byte (queue empty)", D_O);
        end else begin
          check("pix_byte", 32'(D_O), 32'(exp_q.pop_front()));
        end
      end else begin
        check("d_idle", 32'(D_O), 32'h0);
      end
    end
  end

  // action 1: switch MODE_I to 00 on first LV; action 2: drop EN_I on first LV
  task automatic watch_frame(input int exp_fc, input bit need_busy, input int action,
                             output int t_rise);
    int waitn, fv_hi, lv_run, low_run, pulses;
    bit busy_bad, seen_lv;
    waitn = 0; fv_hi = 0; lv_run = 0; low_run = 0; pulses = 0;
    busy_bad = 1'b0; seen_lv = 1'b0;
    @(negedge CLK_I);
    while (!FV_O && waitn < 100) begin
      if (need_busy && !BUSY_O) busy_bad = 1'b1;
      waitn++;
      @(negedge CLK_I);
    end
    t_rise = cyc;
    check("fv_rise", 32'(FV_O), 32'h1);
    if (!FV_O) return;
    while (FV_O && fv_hi < 200) begin
      fv_hi++;
      if (!BUSY_O) busy_bad = 1'b1;
      if (LV_O) begin
        if (lv_run == 0) begin
          if (!seen_lv) begin
            check("fv_lead", 32'(low_run), 32'(FL));
            if (action == 1) MODE_I = 2'b00;
            if (action == 2) EN_I = 1'b0;
          end else begin
            check("lv_gap", 32'(low_run), 32'(HB));
          end
          seen_lv = 1'b1;
        end
        lv_run++;
        low_run = 0;
      end else begin
        if (lv_run > 0) begin
          check("lv_width", 32'(lv_run), 32'(2 * H));
          pulses++;
          lv_run = 0;
        end
        low_run++;
      end
      @(negedge CLK_I);
    end
    check("fv_fall", 32'(FV_O), 32'h0);
    check("lv_trail", 32'(low_run), 32'(HB));
    check("lv_pulses", 32'(pulses), 32'(V));
    check("fv_high", 32'(fv_hi), 32'(FL + V * (2 * H + HB)));
    check("frame_cnt", 32'(FRAME_CNT_O), 32'(exp_fc));
    check("busy_run", 32'(busy_bad), 32'h0);
  endtask

  initial begin
    int t0, t1, t2, tx, n;
    RSTN_I = 1'b1;
    EN_I   = 1'b0;
    MODE_I = 2'b10;
    #3 RSTN_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    check("rst_d",   32'(D_O), 32'h0);
    check("rst_lv",  32'(LV_O), 32'h0);
    check("rst_fv",  32'(FV_O), 32'h0);
    check("rst_busy", 32'(BUSY_O), 32'h0);
    check("rst_fcnt", 32'(FRAME_CNT_O), 32'h0);
    RSTN_I = 1'b1;
    @(negedge CLK_I);
    check("idle_busy", 32'(BUSY_O), 32'h0);

    // flat frames 0 and 1 (mode switched mid-frame 1), then colour bars
    push_frame(2'b10, 16'd0);
    push_frame(2'b10, 16'd1);
    push_frame(2'b00, 16'd2);
    EN_I = 1'b1;
    watch_frame(1, 1'b0, 0, t0);
    watch_frame(2, 1'b1, 1, t1);
    watch_frame(3, 1'b1, 0, t2);
    check("period_0", 32'(t1 - t0), 32'(FL + V * (2 * H + HB) + VB));
    check("period_1", 32'(t2 - t1), 32'(FL + V * (2 * H + HB) + VB));

    MODE_I = 2'b01;
    push_frame(2'b01, 16'd3);
    watch_frame(4, 1'b1, 0, tx);
    MODE_I = 2'b11;
    push_frame(2'b11, 16'd4);
    watch_frame(5, 1'b1, 0, tx);

    // enable dropped during line 0: frame and blank finish, then IDLE
    MODE_I = 2'b00;
    push_frame(2'b00, 16'd5);
    watch_frame(6, 1'b1, 2, tx);
    for (int i = 1; i < VB; i++) begin
      @(negedge CLK_I);
      check("blank_busy", 32'(BUSY_O), 32'h1);
    end
    @(negedge CLK_I);
    check("drop_busy", 32'(BUSY_O), 32'h0);
    check("drop_fv", 32'(FV_O), 32'h0);
    repeat (3) begin
      @(negedge CLK_I);
      check("idle_hold", 32'({BUSY_O, FV_O, LV_O}), 32'h0);
    end

    push_frame(2'b00, 16'd6);
    EN_I = 1'b1;
    @(negedge CLK_I);
    check("restart_fv", 32'(FV_O), 32'h1);
    check("restart_busy", 32'(BUSY_O), 32'h1);

    n = 0;
    while (!LV_O && n < 20) begin
      @(negedge CLK_I);
      n++;
    end
    check("lv_before_reset", 32'(LV_O), 32'h1);
    check("fcnt_before_reset", 32'(FRAME_CNT_O), 32'd6);
    #2 RSTN_I = 1'b0;
    #1;
    check("arst_d",    32'(D_O), 32'h0);
    check("arst_lv",   32'(LV_O), 32'h0);
    check("arst_fv",   32'(FV_O), 32'h0);
    check("arst_busy", 32'(BUSY_O), 32'h0);
    check("arst_fcnt", 32'(FRAME_CNT_O), 32'h0);
    exp_q.delete();
    MODE_I = 2'b11;
    repeat (2) @(negedge CLK_I);
    push_frame(2'b11, 16'd0);
    RSTN_I = 1'b1;
    watch_frame(1, 1'b0, 0, tx);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
